serial_in_rx: RTL and testbench

Serial receiver: the receiving end of the 10-bit serial-out link (idle-high line, start bit, 8 data bits LSB first, stop bit). It oversamples `serial_in` on the system clock, qualifies the start bit at mid-bit, and samples each data bit at mid-bit. It shifts the bits into a SIPO register and presents the completed character with a one-cycle strobe. It sits between the line buffer and the character consumer, as the counterpart of the transmit chain (bit-sampling clock, bit-identification counter, PISO register).

---
 rtl/serial_in_rx.sv | 144 ++++++++++++++
 tb/tb_serial_in_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/serial_in_rx.sv
// serial_in_rx: oversampling 8N1-style serial receiver (start, DATA_BITS LSB-first, stop).
// Optional macro SERIAL_IN_SYNC_EN adds a two-flop input synchronizer ahead of the sampler.
`default_nettype none

module serial_in_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 receive_en,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 char_received,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [SW-1:0] C_MID      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] C_LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SW-1:0]          sample_q, sample_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   strobe_q, strobe_d;
  logic                   fe_q, fe_d;
  logic                   rx;

`ifdef SERIAL_IN_SYNC_EN
  // Reset to 1 so the idle-high line is not mistaken for a start bit after reset.
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], serial_in};
  end
  assign rx = sync_q[1];
`else
  assign rx = serial_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      sample_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      fe_q     <= fe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    fe_d     = fe_q;
    if (!receive_en) begin
      state_d  = IDLE;
      sample_d = '0;
      bit_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d  = START;
            sample_d = '0;
          end
        end
        START: begin
          if (sample_q == C_MID) begin
            sample_d = '0;
            bit_d    = '0;
            state_d  = rx ? IDLE : DATA;
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
        DATA: begin
          if (sample_q == C_LAST) begin
            sample_d = '0;
            // Right shift: the first received bit ends up in bit 0.
            shift_d  = {rx, shift_q[DATA_BITS-1:1]};
            if (bit_q == C_LAST_BIT) begin
              bit_d   = '0;
              state_d = STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
        STOP: begin
          if (sample_q == C_LAST) begin
            sample_d = '0;
            state_d  = IDLE;
            if (rx) begin
              data_d   = shift_q;
              strobe_d = 1'b1;
              fe_d     = 1'b0;
            end else begin
              fe_d = 1'b1;
            end
          end else begin
            sample_d = sample_q + SW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_out      = data_q;
  assign char_received = strobe_q;
  assign framing_error = fe_q;
  assign busy          = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_in_rx.sv
// tb_serial_in_rx: directed frames with a queue-based scoreboard checking each received character.
`default_nettype none

module tb_serial_in_rx;

`ifdef SERIAL_IN_SYNC_EN
  localparam int LAT = 155;
  localparam int SD  = 2;
`else
  localparam int LAT = 153;
  localparam int SD  = 0;
`endif

  logic       clk;
  logic       rst;
  logic       receive_en;
  logic       serial_in;
  logic [7:0] data_out;
  logic       char_received;
  logic       framing_error;
  logic       busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] data;
    time        t0;
  } exp_t;
  exp_t exp_q[$];

  serial_in_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .receive_en   (receive_en),
    .serial_in    (serial_in),
    .data_out     (data_out),
    .char_received(char_received),
    .framing_error(framing_error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected character.
  bit prev_strobe = 1'b0;
  always @(negedge clk) begin
    if (char_received === 1'b1) begin
      check("strobe_gap", 32'(prev_strobe), 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got strobe with data %0h required none", data_out);
      end else begin
        exp_t e;
        int   lat;
        e   = exp_q.pop_front();
        lat = int'(($time - e.t0 - 5) / 10) + 1;
        check("rx_data", 32'(data_out), 32'(e.data));
        check("rx_latency", 32'(lat), 32'(LAT));
        check("rx_fe", 32'(framing_error), 32'd0);
        check("rx_busy", 32'(busy), 32'd0);
      end
    end
    prev_strobe = (char_received === 1'b1);
  end

  // Called at a negedge; the following posedge is edge 0 of the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic expect_rx);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (expect_rx) exp_q.push_back('{data: d, t0: $time + 5});
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat (16) @(negedge clk);
    end
    serial_in = 1'b1;
  endtask

  task automatic abort_frame(input logic [7:0] d, input logic use_rst);
    logic [9:0] bits;
    bits = {1'b1, d, 1'b0};
    for (int c = 0; c < 160; c++) begin
      serial_in = bits[c / 16];
      if (c == 70) begin
        check("abort_busy_before", 32'(busy), 32'd1);
        if (use_rst) begin
          rst = 1'b0;
          #1;
          check("rst_data", 32'(data_out), 32'd0);
          check("rst_strobe", 32'(char_received), 32'd0);
          check("rst_fe", 32'(framing_error), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
        end else begin
          receive_en = 1'b0;
        end
      end
      if (c == 71 && !use_rst) check("dis_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    serial_in  = 1'b1;
    rst        = 1'b1;
    receive_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b0;
    receive_en = 1'b0;
    serial_in  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_strobe", 32'(char_received), 32'd0);
    check("reset_fe", 32'(framing_error), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst        = 1'b1;
    receive_en = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h99, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("f99_data", 32'(data_out), 32'h99);
    check("f99_fe", 32'(framing_error), 32'd0);
    check("f99_busy", 32'(busy), 32'd0);

    // Short start pulse: busy only while START waits for mid-bit.
    serial_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("glitch_busy", 32'(busy), (i >= 1 + SD && i <= 8 + SD) ? 32'd1 : 32'd0);
      if (i == 4) serial_in = 1'b1;
    end
    check("glitch_data", 32'(data_out), 32'h99);

    send_frame(8'h5A, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("ferr_flag", 32'(framing_error), 32'd1);
    check("ferr_data", 32'(data_out), 32'h99);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("after_ferr_data", 32'(data_out), 32'h3C);
    check("after_ferr_fe", 32'(framing_error), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    repeat (10) @(negedge clk);

    abort_frame(8'hF0, 1'b0);
    check("dis_data_hold", 32'(data_out), 32'h3C);
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    check("f81_data", 32'(data_out), 32'h81);

    abort_frame(8'h0F, 1'b1);
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("rst_f81_data", 32'(data_out), 32'h81);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
